// File: rtl/packet_sink_pkg.sv
// Shared packet layout, field widths and drain FSM encoding for the ejection-port sink.
package packet_sink_pkg;

    localparam int unsigned NUM_NODES    = 16;
    localparam int unsigned ADDR_BITS    = $clog2(NUM_NODES);
    localparam int unsigned PAYLOAD_SIZE = 8;
    localparam int unsigned DATA_W       = PAYLOAD_SIZE + ADDR_BITS;

    // Source id sits above the destination address on the wire.
    typedef struct packed {
        logic [PAYLOAD_SIZE-1:0] src;
        logic [ADDR_BITS-1:0]    dest;
    } pkt_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_POP  = 2'd2
    } sink_state_e;

endpackage

// File: rtl/sink_fifo.sv
// Small circular buffer with registered full/empty/occupancy flags (DEPTH must be a power of 2).
module sink_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wr_data,
    output logic [WIDTH-1:0]       rd_data_c,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] occupancy
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned OW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [OW-1:0]    occ_next;

    always_comb begin
        occ_next = occupancy;
        if (push && !pop) begin
            occ_next = occupancy + OW'(1);
        end else if (pop && !push) begin
            occ_next = occupancy - OW'(1);
        end
    end

    // Flags come from next-state occupancy so they are valid the cycle after the update.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
            full      <= 1'b0;
            empty     <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            occupancy <= occ_next;
            full      <= (occ_next == OW'(DEPTH));
            empty     <= (occ_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    assign rd_data_c = mem[rd_ptr];

endmodule

// File: rtl/packet_sink.sv
// Ejection-port packet sink: buffers packets, drains one per DRAIN_PERIOD cycles, keeps statistics.
// Define SINK_LOG_EN to print a "##,rx,<id>,<src>" line on every pop for tx/rx pairing scripts.
module packet_sink
    import packet_sink_pkg::*;
#(
    parameter int          id           = -1,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned DRAIN_PERIOD = 2,
    parameter int unsigned CNT_BITS     = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_W-1:0]       data,
    input  logic                    req,
    output logic                    busy,
    output logic [CNT_BITS-1:0]     rx_count,
    output logic [CNT_BITS-1:0]     misroute_count,
    output logic [CNT_BITS-1:0]     drop_count,
    output logic [PAYLOAD_SIZE-1:0] last_src,
    output logic                    rx_valid
);

    localparam int unsigned OW = $clog2(DEPTH) + 1;
    localparam int unsigned DW = $clog2(DRAIN_PERIOD + 1);

    sink_state_e       state;
    sink_state_e       state_next;
    logic [DW-1:0]     drain_cnt;
    logic [DW-1:0]     drain_cnt_next;
    logic [DATA_W-1:0] rd_data;
    logic [OW-1:0]     occupancy;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    pkt_t              pkt;
    logic              dest_match;

    assign push       = req && !busy;
    assign pop        = (state == S_POP);
    assign pkt        = pkt_t'(rd_data);
    assign dest_match = (int'(pkt.dest) == id);
    assign busy       = fifo_full;

    sink_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .wr_data   (data),
        .rd_data_c (rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .occupancy (occupancy)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            drain_cnt <= '0;
        end else begin
            state     <= state_next;
            drain_cnt <= drain_cnt_next;
        end
    end

    // WAIT spans DRAIN_PERIOD-1 cycles so consecutive pops are DRAIN_PERIOD apart.
    always_comb begin
        state_next     = state;
        drain_cnt_next = drain_cnt;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    if (DRAIN_PERIOD == 1) begin
                        state_next = S_POP;
                    end else begin
                        state_next     = S_WAIT;
                        drain_cnt_next = DW'(DRAIN_PERIOD - 1);
                    end
                end
            end
            S_WAIT: begin
                drain_cnt_next = drain_cnt - DW'(1);
                if (drain_cnt <= DW'(1)) begin
                    state_next     = S_POP;
                    drain_cnt_next = '0;
                end
            end
            S_POP: begin
                if (occupancy > OW'(1)) begin
                    if (DRAIN_PERIOD == 1) begin
                        state_next = S_POP;
                    end else begin
                        state_next     = S_WAIT;
                        drain_cnt_next = DW'(DRAIN_PERIOD - 1);
                    end
                end else begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Statistics saturate at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_count       <= '0;
            misroute_count <= '0;
            drop_count     <= '0;
            last_src       <= '0;
            rx_valid       <= 1'b0;
        end else begin
            rx_valid <= (state_next == S_POP);
            if (req && busy && (drop_count != '1)) begin
                drop_count <= drop_count + CNT_BITS'(1);
            end
            if (pop) begin
                last_src <= pkt.src;
                if (dest_match) begin
                    if (rx_count != '1) rx_count <= rx_count + CNT_BITS'(1);
                end else begin
                    if (misroute_count != '1) misroute_count <= misroute_count + CNT_BITS'(1);
                end
            end
        end
    end

`ifdef SINK_LOG_EN
    always_ff @(posedge clk) begin
        if (!reset && pop) $display("##,rx,%d,%d", id, pkt.src);
    end
`else
`endif

endmodule

// File: tb/tb_packet_sink.sv
// Bench for packet_sink: directed scenarios on three configurations plus a randomized queue-model run.
module tb_packet_sink;
    import packet_sink_pkg::*;

    localparam int M_ID    = 3;
    localparam int M_DEPTH = 4;
    localparam int M_DP    = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    logic [DATA_W-1:0]       m_data = '0, s_data = '0, f_data = '0;
    logic                    m_req = 1'b0, s_req = 1'b0, f_req = 1'b0;
    logic                    m_busy, s_busy, f_busy;
    logic                    m_rxv, s_rxv, f_rxv;
    logic [15:0]             m_rx, m_mis, m_drop, s_rx, s_mis, s_drop;
    logic [1:0]              f_rx, f_mis, f_drop;
    logic [PAYLOAD_SIZE-1:0] m_src, s_src, f_src;

    int compares = 0;
    int errors   = 0;

    always #5 clk = ~clk;

    packet_sink #(.id(M_ID), .DEPTH(M_DEPTH), .DRAIN_PERIOD(M_DP), .CNT_BITS(16)) u_main (
        .clk(clk), .reset(reset), .data(m_data), .req(m_req), .busy(m_busy),
        .rx_count(m_rx), .misroute_count(m_mis), .drop_count(m_drop),
        .last_src(m_src), .rx_valid(m_rxv));

    packet_sink #(.id(3), .DEPTH(4), .DRAIN_PERIOD(8), .CNT_BITS(16)) u_slow (
        .clk(clk), .reset(reset), .data(s_data), .req(s_req), .busy(s_busy),
        .rx_count(s_rx), .misroute_count(s_mis), .drop_count(s_drop),
        .last_src(s_src), .rx_valid(s_rxv));

    packet_sink #(.id(3), .DEPTH(4), .DRAIN_PERIOD(1), .CNT_BITS(2)) u_fast (
        .clk(clk), .reset(reset), .data(f_data), .req(f_req), .busy(f_busy),
        .rx_count(f_rx), .misroute_count(f_mis), .drop_count(f_drop),
        .last_src(f_src), .rx_valid(f_rxv));

    function automatic logic [DATA_W-1:0] mk(input int src, input int dest);
        pkt_t p;
        p.src  = PAYLOAD_SIZE'(src);
        p.dest = ADDR_BITS'(dest);
        return p;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        m_req = 1'b0; s_req = 1'b0; f_req = 1'b0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        compares += 8;
        if (m_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", m_busy); end
        if (m_rx !== 16'd0) begin errors++; $display("FAIL reset_rx got %0d exp 0", m_rx); end
        if (m_mis !== 16'd0) begin errors++; $display("FAIL reset_mis got %0d exp 0", m_mis); end
        if (m_drop !== 16'd0) begin errors++; $display("FAIL reset_drop got %0d exp 0", m_drop); end
        if (m_src !== '0) begin errors++; $display("FAIL reset_src got %0d exp 0", m_src); end
        if (m_rxv !== 1'b0) begin errors++; $display("FAIL reset_rxv got %0b exp 0", m_rxv); end
        if (s_busy !== 1'b0) begin errors++; $display("FAIL reset_slow_busy got %0b exp 0", s_busy); end
        if (f_rx !== 2'd0) begin errors++; $display("FAIL reset_fast_rx got %0d exp 0", f_rx); end
    endtask

    task automatic test_single_rx();
        do_reset();
        m_data = mk(0, 3);
        m_req  = 1'b1;
        step();
        m_req = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            compares++;
            if (m_rxv !== (k == 3)) begin
                errors++;
                $display("FAIL single_latency cycle t+%0d got %0b exp %0b", k, m_rxv, (k == 3));
            end
            step();
        end
        compares += 3;
        if (m_rx !== 16'd1) begin errors++; $display("FAIL single_rx got %0d exp 1", m_rx); end
        if (m_mis !== 16'd0) begin errors++; $display("FAIL single_mis got %0d exp 0", m_mis); end
        if (m_src !== 8'd0) begin errors++; $display("FAIL single_src got %0d exp 0", m_src); end
    endtask

    task automatic test_misroute();
        do_reset();
        m_data = mk(1, 5);
        m_req  = 1'b1;
        step();
        m_req = 1'b0;
        repeat (5) step();
        compares += 3;
        if (m_mis !== 16'd1) begin errors++; $display("FAIL misroute_mis got %0d exp 1", m_mis); end
        if (m_rx !== 16'd0) begin errors++; $display("FAIL misroute_rx got %0d exp 0", m_rx); end
        if (m_src !== 8'd1) begin errors++; $display("FAIL misroute_src got %0d exp 1", m_src); end
    endtask

    task automatic test_back_to_back();
        int pops = 0;
        int cyc  = 0;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            s_data = mk(i, 3);
            s_req  = 1'b1;
            compares++;
            if (s_busy !== (i >= 4)) begin
                errors++;
                $display("FAIL b2b_busy req %0d got %0b exp %0b", i, s_busy, (i >= 4));
            end
            step();
        end
        s_req = 1'b0;
        compares++;
        if (s_drop !== 16'd2) begin errors++; $display("FAIL b2b_drop got %0d exp 2", s_drop); end
        while (pops < 4 && cyc < 80) begin
            if (s_rxv === 1'b1) pops++;
            step();
            cyc++;
        end
        step();
        compares += 5;
        if (pops != 4) begin errors++; $display("FAIL b2b_drain_timeout got %0d pops exp 4", pops); end
        if (s_rx !== 16'd4) begin errors++; $display("FAIL b2b_rx got %0d exp 4", s_rx); end
        if (s_mis !== 16'd0) begin errors++; $display("FAIL b2b_mis got %0d exp 0", s_mis); end
        if (s_src !== 8'd3) begin errors++; $display("FAIL b2b_last_src got %0d exp 3", s_src); end
        if (s_busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_end got %0b exp 0", s_busy); end
    endtask

    task automatic test_drain_fast();
        do_reset();
        for (int k = 0; k < 7; k++) begin
            f_req  = (k < 3);
            f_data = mk(7 + k, 3);
            compares++;
            if (f_rxv !== (k >= 2 && k <= 4)) begin
                errors++;
                $display("FAIL fast_rxv cycle t+%0d got %0b exp %0b", k, f_rxv, (k >= 2 && k <= 4));
            end
            if (k >= 3 && k <= 5) begin
                compares++;
                if (f_src !== 8'(7 + k - 3)) begin
                    errors++;
                    $display("FAIL fast_order cycle t+%0d got %0d exp %0d", k, f_src, 7 + k - 3);
                end
            end
            step();
        end
        f_req = 1'b0;
        compares++;
        if (f_rx !== 2'd3) begin errors++; $display("FAIL fast_rx got %0d exp 3", f_rx); end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int p = 0; p < 5; p++) begin
            f_data = mk(p, 3);
            f_req  = 1'b1;
            step();
            f_req = 1'b0;
            repeat (4) step();
            compares++;
            if (f_rx !== 2'((p + 1 > 3) ? 3 : p + 1)) begin
                errors++;
                $display("FAIL sat_rx after %0d got %0d exp %0d", p + 1, f_rx, (p + 1 > 3) ? 3 : p + 1);
            end
        end
        compares++;
        if (f_mis !== 2'd0) begin errors++; $display("FAIL sat_mis got %0d exp 0", f_mis); end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            m_data = mk(i + 10, 3);
            m_req  = 1'b1;
            step();
        end
        m_req = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        compares += 5;
        if (m_busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %0b exp 0", m_busy); end
        if (m_rx !== 16'd0) begin errors++; $display("FAIL rmid_rx got %0d exp 0", m_rx); end
        if (m_mis !== 16'd0) begin errors++; $display("FAIL rmid_mis got %0d exp 0", m_mis); end
        if (m_drop !== 16'd0) begin errors++; $display("FAIL rmid_drop got %0d exp 0", m_drop); end
        if (m_rxv !== 1'b0) begin errors++; $display("FAIL rmid_rxv got %0b exp 0", m_rxv); end
        for (int k = 0; k < 12; k++) begin
            if (m_rxv !== 1'b0) seen++;
            step();
        end
        compares += 2;
        if (seen != 0) begin errors++; $display("FAIL rmid_stale_pop got %0d pulses exp 0", seen); end
        if (m_rx !== 16'd0) begin errors++; $display("FAIL rmid_rx_after got %0d exp 0", m_rx); end
    endtask

    // Reference: a packet queue plus the next scheduled pop time derived from the drain rate.
    task automatic test_random();
        pkt_t q[$];
        pkt_t p;
        pkt_t pk;
        int   next_pop = -1;
        int   exp_rx = 0, exp_mis = 0, exp_drop = 0, exp_src = 0;
        logic exp_v, r, was_full, had_more, pushed;
        do_reset();
        for (int c = 0; c < 500; c++) begin
            exp_v    = (c == next_pop);
            was_full = (q.size() == M_DEPTH);
            compares += 6;
            if (m_busy !== was_full) begin errors++; $display("FAIL rand_busy c=%0d got %0b exp %0b", c, m_busy, was_full); end
            if (m_rxv !== exp_v) begin errors++; $display("FAIL rand_rxv c=%0d got %0b exp %0b", c, m_rxv, exp_v); end
            if (m_rx !== 16'(exp_rx)) begin errors++; $display("FAIL rand_rx c=%0d got %0d exp %0d", c, m_rx, exp_rx); end
            if (m_mis !== 16'(exp_mis)) begin errors++; $display("FAIL rand_mis c=%0d got %0d exp %0d", c, m_mis, exp_mis); end
            if (m_drop !== 16'(exp_drop)) begin errors++; $display("FAIL rand_drop c=%0d got %0d exp %0d", c, m_drop, exp_drop); end
            if (m_src !== 8'(exp_src)) begin errors++; $display("FAIL rand_src c=%0d got %0d exp %0d", c, m_src, exp_src); end

            r      = ($urandom_range(0, 99) < 55);
            p.src  = PAYLOAD_SIZE'($urandom_range(0, 255));
            p.dest = ($urandom_range(0, 2) == 0) ? ADDR_BITS'($urandom_range(0, 15)) : ADDR_BITS'(M_ID);
            m_req  = r;
            m_data = p;

            pushed = 1'b0;
            if (exp_v) begin
                had_more = (q.size() > 1);
                pk = q.pop_front();
                if (int'(pk.dest) == M_ID) exp_rx++;
                else exp_mis++;
                exp_src  = int'(pk.src);
                next_pop = had_more ? c + M_DP : -1;
            end
            if (r) begin
                if (was_full) exp_drop++;
                else begin
                    q.push_back(p);
                    pushed = 1'b1;
                end
            end
            if (pushed && next_pop < 0) next_pop = c + 1 + M_DP;
            step();
        end
        m_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_rx();
        test_misroute();
        test_back_to_back();
        test_drain_fast();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, errors);
        $finish;
    end

endmodule
